// File: rtl/alarm_clock_multi_if.sv
// Control/status bundle between the panel buttons, the alarm clock core and the display decode.
// Master drives buttons, mode and enables; slave returns BCD time, alarm readback and ring status.
interface alarm_clock_multi_if #(
    parameter int NUM_ALARMS = 4
);
    localparam int SW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

    logic [1:0]            mode;
    logic [SW-1:0]         alarm_sel;
    logic                  inc_hr;
    logic                  inc_min;
    logic [NUM_ALARMS-1:0] alarm_en;
    logic                  snooze;
    logic                  stop;
    logic                  hour12;
    logic [23:0]           time_bcd;
    logic [15:0]           alarm_bcd;
    logic                  pm;
    logic                  tick;
    logic                  ring;
    logic [SW-1:0]         ring_id;
    logic                  snoozing;

    modport master (
        output mode, alarm_sel, inc_hr, inc_min, alarm_en, snooze, stop, hour12,
        input  time_bcd, alarm_bcd, pm, tick, ring, ring_id, snoozing
    );

    modport slave (
        input  mode, alarm_sel, inc_hr, inc_min, alarm_en, snooze, stop, hour12,
        output time_bcd, alarm_bcd, pm, tick, ring, ring_id, snoozing
    );
endinterface

// File: rtl/alarm_clock_multi.sv
// 24-hour BCD clock with NUM_ALARMS alarms, snooze, ring auto-silence and 12/24 h display.
// Latency: ring/snoozing one cycle after the triggering tick or button edge, display combinational; no backpressure.
module alarm_clock_multi #(
    parameter int CLK_HZ           = 50000000,
    parameter int NUM_ALARMS       = 4,
    parameter int SNOOZE_MIN       = 5,
    parameter int RING_TIMEOUT_MIN = 2
) (
    input  logic                clk,
    input  logic                rst,
    alarm_clock_multi_if.slave  bus
);
    localparam int SW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;
    localparam int PW = $clog2(CLK_HZ);

    typedef enum logic [1:0] {S_IDLE, S_RINGING, S_SNOOZED} state_t;

    function automatic logic [7:0] bcd_inc60(input logic [7:0] v);
        if (v == 8'h59)          return 8'h00;
        else if (v[3:0] == 4'h9) return {v[7:4] + 4'd1, 4'h0};
        else                     return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_inc24(input logic [7:0] v);
        if (v == 8'h23)          return 8'h00;
        else if (v[3:0] == 4'h9) return {v[7:4] + 4'd1, 4'h0};
        else                     return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Returns {pm, hh} for 12-hour display of a 24-hour BCD hour.
    function automatic logic [8:0] fmt12(input logic [7:0] h);
        case (h[7:4])
            4'h0: return (h[3:0] == 4'h0) ? {1'b0, 8'h12} : {1'b0, h};
            4'h1: begin
                if (h[3:0] < 4'h2)       return {1'b0, h};
                else if (h[3:0] == 4'h2) return {1'b1, 8'h12};
                else                     return {1'b1, 4'h0, h[3:0] - 4'd2};
            end
            4'h2: begin
                if (h[3:0] < 4'h2) return {1'b1, 4'h0, h[3:0] + 4'd8};
                else               return {1'b1, 4'h1, h[3:0] - 4'd2};
            end
            default: return {1'b0, h};
        endcase
    endfunction

    logic set_time, set_alarm;
    assign set_time  = (bus.mode == 2'b01);
    assign set_alarm = (bus.mode == 2'b10);

    // armed masks the first cycle after reset so a button held through reset never fires.
    logic armed, prev_hr, prev_min, prev_snz, prev_stop;
    logic ev_hr, ev_min, ev_snz, ev_stop;

    always_ff @(posedge clk) begin
        if (!rst) begin
            armed     <= 1'b0;
            prev_hr   <= 1'b0;
            prev_min  <= 1'b0;
            prev_snz  <= 1'b0;
            prev_stop <= 1'b0;
        end else begin
            armed     <= 1'b1;
            prev_hr   <= bus.inc_hr;
            prev_min  <= bus.inc_min;
            prev_snz  <= bus.snooze;
            prev_stop <= bus.stop;
        end
    end

    assign ev_hr   = armed & bus.inc_hr  & ~prev_hr;
    assign ev_min  = armed & bus.inc_min & ~prev_min;
    assign ev_snz  = armed & bus.snooze  & ~prev_snz;
    assign ev_stop = armed & bus.stop    & ~prev_stop;

    logic [PW-1:0] pre;
    logic          tick_i;
    assign tick_i = !set_time && (pre == PW'(CLK_HZ - 1));

    always_ff @(posedge clk) begin
        if (!rst)                   pre <= '0;
        else if (set_time || tick_i) pre <= '0;
        else                        pre <= pre + PW'(1);
    end

    logic [7:0] hh, mm, ss;
    logic [7:0] hh_next, mm_next;
    logic       ss_wrap, mm_wrap;

    assign ss_wrap = tick_i && (ss == 8'h59);
    assign mm_wrap = ss_wrap && (mm == 8'h59);
    assign mm_next = ss_wrap ? bcd_inc60(mm) : mm;
    assign hh_next = mm_wrap ? bcd_inc24(hh) : hh;

    always_ff @(posedge clk) begin
        if (!rst) begin
            hh <= 8'h00;
            mm <= 8'h00;
            ss <= 8'h00;
        end else if (set_time) begin
            ss <= 8'h00;
            if (ev_min) mm <= bcd_inc60(mm);
            if (ev_hr)  hh <= bcd_inc24(hh);
        end else if (tick_i) begin
            ss <= bcd_inc60(ss);
            mm <= mm_next;
            hh <= hh_next;
        end
    end

    logic [7:0]    al_hh [NUM_ALARMS];
    logic [7:0]    al_mm [NUM_ALARMS];
    logic [SW-1:0] sel_q;
    logic          sel_ok;
    assign sel_ok = (int'(sel_q) < NUM_ALARMS);

    always_ff @(posedge clk) begin
        if (!rst) begin
            sel_q <= '0;
            for (int i = 0; i < NUM_ALARMS; i++) begin
                al_hh[i] <= 8'h00;
                al_mm[i] <= 8'h00;
            end
        end else begin
            sel_q <= bus.alarm_sel;
            if (set_alarm && sel_ok) begin
                if (ev_hr)  al_hh[sel_q] <= bcd_inc24(al_hh[sel_q]);
                if (ev_min) al_mm[sel_q] <= bcd_inc60(al_mm[sel_q]);
            end
        end
    end

    // Descending scan so the lowest matching slot is the one that sticks.
    logic          hit;
    logic [SW-1:0] hit_id;
    always_comb begin
        hit    = 1'b0;
        hit_id = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (bus.alarm_en[i] && al_hh[i] == hh_next && al_mm[i] == mm_next) begin
                hit    = 1'b1;
                hit_id = SW'(i);
            end
        end
    end

    state_t        state, state_n;
    logic [5:0]    tmr, tmr_n, tmr_inc;
    logic [SW-1:0] id_q, id_n;
    assign tmr_inc = tmr + 6'd1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
            tmr   <= 6'd0;
            id_q  <= '0;
        end else begin
            state <= state_n;
            tmr   <= tmr_n;
            id_q  <= id_n;
        end
    end

    always_comb begin
        state_n = state;
        tmr_n   = tmr;
        id_n    = id_q;
        if (set_time) begin
            state_n = S_IDLE;
        end else if (state != S_IDLE && !bus.alarm_en[id_q]) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ss_wrap && hit) begin
                        state_n = S_RINGING;
                        id_n    = hit_id;
                        tmr_n   = 6'd0;
                    end
                end
                S_RINGING: begin
                    if (ev_stop) begin
                        state_n = S_IDLE;
                    end else if (ev_snz) begin
                        state_n = S_SNOOZED;
                        tmr_n   = 6'd0;
                    end else if (mm_wrap || ss_wrap) begin
                        if (tmr_inc == 6'(RING_TIMEOUT_MIN)) state_n = S_IDLE;
                        else                                 tmr_n   = tmr_inc;
                    end
                end
                S_SNOOZED: begin
                    if (ev_stop) begin
                        state_n = S_IDLE;
                    end else if (ss_wrap) begin
                        if (tmr_inc == 6'(SNOOZE_MIN)) begin
                            state_n = S_RINGING;
                            tmr_n   = 6'd0;
                        end else begin
                            tmr_n = tmr_inc;
                        end
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    logic [8:0] t_disp, a_disp;
    logic [7:0] a_hh, a_mm;
    assign a_hh = sel_ok ? al_hh[sel_q] : 8'h00;
    assign a_mm = sel_ok ? al_mm[sel_q] : 8'h00;

    always_comb begin
        t_disp = {1'b0, hh};
        a_disp = {1'b0, a_hh};
        if (bus.hour12) begin
            t_disp = fmt12(hh);
            a_disp = fmt12(a_hh);
        end
    end

    assign bus.time_bcd  = {t_disp[7:0], mm, ss};
    assign bus.alarm_bcd = {a_disp[7:0], a_mm};
    assign bus.pm        = t_disp[8];
    assign bus.tick      = tick_i;
    assign bus.ring      = (state == S_RINGING);
    assign bus.snoozing  = (state == S_SNOOZED);
    assign bus.ring_id   = id_q;
endmodule

// File: tb/tb_alarm_clock_multi.sv
// Directed bench for alarm_clock_multi at CLK_HZ=4: inputs driven and outputs sampled on the falling edge.
module tb_alarm_clock_multi;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    alarm_clock_multi_if #(.NUM_ALARMS(4)) bus ();

    alarm_clock_multi #(
        .CLK_HZ(4), .NUM_ALARMS(4), .SNOOZE_MIN(5), .RING_TIMEOUT_MIN(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_hr(input int n);
        repeat (n) begin
            bus.inc_hr = 1'b1; step(1);
            bus.inc_hr = 1'b0; step(1);
        end
    endtask

    task automatic press_min(input int n);
        repeat (n) begin
            bus.inc_min = 1'b1; step(1);
            bus.inc_min = 1'b0; step(1);
        end
    endtask

    // Bounded wait for a displayed time; an expired bound counts as a miscompare.
    task automatic wait_time(input logic [23:0] t, input int budget, input string name);
        int k = 0;
        while (bus.time_bcd !== t && k < budget) begin
            step(1);
            k++;
        end
        vectors++;
        if (bus.time_bcd !== t) begin
            miscompares++;
            $display("FAIL %s: time_bcd=%h expected %h after %0d cycles", name, bus.time_bcd, t, k);
        end
    endtask

    task automatic test_reset;
        bus.mode = 2'b01;
        bus.inc_hr = 1'b1;
        rst = 1'b0;
        step(3);
        vectors++;
        if (bus.time_bcd !== 24'h000000 || bus.alarm_bcd !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_time: time=%h alarm=%h expected 000000/0000", bus.time_bcd, bus.alarm_bcd);
        end
        vectors++;
        if ({bus.ring, bus.snoozing, bus.ring_id, bus.tick, bus.pm} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_status: ring=%b snz=%b id=%0d tick=%b pm=%b expected all 0",
                     bus.ring, bus.snoozing, bus.ring_id, bus.tick, bus.pm);
        end
        rst = 1'b1;
        step(4);
        vectors++;
        if (bus.time_bcd !== 24'h000000) begin
            miscompares++;
            $display("FAIL held_button: time=%h expected 000000", bus.time_bcd);
        end
        bus.inc_hr = 1'b0;
        bus.mode = 2'b00;
    endtask

    task automatic test_tick;
        int ticks = 0;
        int first = -1;
        rst = 1'b0; step(2); rst = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            step(1);
            if (bus.tick === 1'b1) begin
                ticks++;
                if (first < 0) first = c;
            end
        end
        vectors++;
        if (ticks != 10 || first != 3) begin
            miscompares++;
            $display("FAIL tick_rate: ticks=%0d first=%0d expected 10/3", ticks, first);
        end
        vectors++;
        if (bus.time_bcd !== 24'h000010 || bus.ring !== 1'b0 || bus.pm !== 1'b0) begin
            miscompares++;
            $display("FAIL run_10s: time=%h ring=%b pm=%b expected 000010/0/0", bus.time_bcd, bus.ring, bus.pm);
        end
    endtask

    task automatic test_set_time;
        bus.mode = 2'b01;
        step(1);
        press_hr(23);
        press_min(59);
        vectors++;
        if (bus.time_bcd !== 24'h235900) begin
            miscompares++;
            $display("FAIL set_2359: time=%h expected 235900", bus.time_bcd);
        end
        bus.mode = 2'b00;
        step(240);
        vectors++;
        if (bus.time_bcd !== 24'h000000) begin
            miscompares++;
            $display("FAIL day_wrap: time=%h expected 000000", bus.time_bcd);
        end
        bus.mode = 2'b01;
        step(1);
        press_min(60);
        vectors++;
        if (bus.time_bcd !== 24'h000000) begin
            miscompares++;
            $display("FAIL min_wrap_no_carry: time=%h expected 000000", bus.time_bcd);
        end
        bus.inc_min = 1'b1; step(5); bus.inc_min = 1'b0; step(1);
        vectors++;
        if (bus.time_bcd !== 24'h000100) begin
            miscompares++;
            $display("FAIL held_min_once: time=%h expected 000100", bus.time_bcd);
        end
        bus.inc_hr = 1'b1; bus.inc_min = 1'b1; step(1);
        bus.inc_hr = 1'b0; bus.inc_min = 1'b0; step(1);
        vectors++;
        if (bus.time_bcd !== 24'h010200) begin
            miscompares++;
            $display("FAIL both_edges: time=%h expected 010200", bus.time_bcd);
        end
        bus.mode = 2'b00;
    endtask

    task automatic test_alarm_snooze_timeout;
        rst = 1'b0; step(2); rst = 1'b1;
        bus.mode = 2'b10;
        bus.alarm_sel = 2'd1; step(1); press_hr(7);
        bus.alarm_sel = 2'd2; step(1); press_hr(7);
        vectors++;
        if (bus.alarm_bcd !== 16'h0700) begin
            miscompares++;
            $display("FAIL alarm2_set: alarm=%h expected 0700", bus.alarm_bcd);
        end
        bus.alarm_sel = 2'd0; step(1);
        vectors++;
        if (bus.alarm_bcd !== 16'h0000) begin
            miscompares++;
            $display("FAIL alarm0_untouched: alarm=%h expected 0000", bus.alarm_bcd);
        end
        bus.mode = 2'b01; step(1);
        press_hr(6); press_min(59);
        bus.alarm_en = 4'b0110;
        bus.mode = 2'b00;
        step(236);
        vectors++;
        if (bus.time_bcd !== 24'h065959 || bus.ring !== 1'b0) begin
            miscompares++;
            $display("FAIL pre_alarm: time=%h ring=%b expected 065959/0", bus.time_bcd, bus.ring);
        end
        step(4);
        vectors++;
        if (bus.time_bcd !== 24'h070000 || bus.ring !== 1'b1 || bus.ring_id !== 2'd1) begin
            miscompares++;
            $display("FAIL ring_0700: time=%h ring=%b id=%0d expected 070000/1/1",
                     bus.time_bcd, bus.ring, bus.ring_id);
        end
        step(40);
        wait_time(24'h070010, 4, "reach_070010");
        bus.snooze = 1'b1; step(1); bus.snooze = 1'b0;
        vectors++;
        if (bus.ring !== 1'b0 || bus.snoozing !== 1'b1) begin
            miscompares++;
            $display("FAIL snooze_enter: ring=%b snz=%b expected 0/1", bus.ring, bus.snoozing);
        end
        wait_time(24'h070459, 1300, "reach_070459");
        vectors++;
        if (bus.ring !== 1'b0 || bus.snoozing !== 1'b1) begin
            miscompares++;
            $display("FAIL still_snoozed: ring=%b snz=%b expected 0/1", bus.ring, bus.snoozing);
        end
        wait_time(24'h070500, 8, "reach_070500");
        vectors++;
        if (bus.ring !== 1'b1 || bus.snoozing !== 1'b0 || bus.ring_id !== 2'd1) begin
            miscompares++;
            $display("FAIL re_ring: ring=%b snz=%b id=%0d expected 1/0/1", bus.ring, bus.snoozing, bus.ring_id);
        end
        wait_time(24'h070659, 600, "reach_070659");
        vectors++;
        if (bus.ring !== 1'b1) begin
            miscompares++;
            $display("FAIL ring_before_timeout: ring=%b expected 1", bus.ring);
        end
        wait_time(24'h070700, 8, "reach_070700");
        vectors++;
        if (bus.ring !== 1'b0 || bus.snoozing !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_silence: ring=%b snz=%b expected 0/0", bus.ring, bus.snoozing);
        end
    endtask

    task automatic test_stop_snooze_same;
        bus.mode = 2'b01; step(1);
        press_min(1);
        bus.mode = 2'b10; bus.alarm_sel = 2'd0; step(1);
        press_hr(7); press_min(9);
        vectors++;
        if (bus.alarm_bcd !== 16'h0709) begin
            miscompares++;
            $display("FAIL alarm0_set: alarm=%h expected 0709", bus.alarm_bcd);
        end
        bus.alarm_en = 4'b0111;
        bus.mode = 2'b00;
        wait_time(24'h070900, 300, "reach_070900");
        vectors++;
        if (bus.ring !== 1'b1 || bus.ring_id !== 2'd0) begin
            miscompares++;
            $display("FAIL ring_0709: ring=%b id=%0d expected 1/0", bus.ring, bus.ring_id);
        end
        bus.snooze = 1'b1; bus.stop = 1'b1; step(1);
        bus.snooze = 1'b0; bus.stop = 1'b0; step(8);
        vectors++;
        if (bus.ring !== 1'b0 || bus.snoozing !== 1'b0) begin
            miscompares++;
            $display("FAIL stop_wins: ring=%b snz=%b expected 0/0", bus.ring, bus.snoozing);
        end
    endtask

    task automatic test_enable_clear;
        bus.mode = 2'b10; step(1);
        press_min(1);
        bus.mode = 2'b00;
        wait_time(24'h071000, 300, "reach_071000");
        vectors++;
        if (bus.ring !== 1'b1) begin
            miscompares++;
            $display("FAIL ring_0710: ring=%b expected 1", bus.ring);
        end
        bus.alarm_en = 4'b0110; step(1);
        vectors++;
        if (bus.ring !== 1'b0) begin
            miscompares++;
            $display("FAIL enable_clear: ring=%b expected 0", bus.ring);
        end
    endtask

    task automatic test_reset_while_snoozing;
        bus.alarm_en = 4'b0111;
        bus.mode = 2'b10; step(1);
        press_min(1);
        bus.mode = 2'b00;
        wait_time(24'h071100, 300, "reach_071100");
        bus.snooze = 1'b1; step(1); bus.snooze = 1'b0;
        vectors++;
        if (bus.snoozing !== 1'b1) begin
            miscompares++;
            $display("FAIL snooze_0711: snz=%b expected 1", bus.snoozing);
        end
        rst = 1'b0; step(1);
        vectors++;
        if (bus.time_bcd !== 24'h000000 || bus.alarm_bcd !== 16'h0000 ||
            {bus.ring, bus.snoozing, bus.ring_id, bus.tick, bus.pm} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_mid_snooze: time=%h alarm=%h ring=%b snz=%b id=%0d expected zeros",
                     bus.time_bcd, bus.alarm_bcd, bus.ring, bus.snoozing, bus.ring_id);
        end
        rst = 1'b1;
        bus.alarm_en = 4'b0000;
    endtask

    task automatic test_hour12;
        bus.hour12 = 1'b1;
        bus.mode = 2'b01; step(1);
        press_min(30);
        vectors++;
        if (bus.time_bcd !== 24'h123000 || bus.pm !== 1'b0) begin
            miscompares++;
            $display("FAIL h12_0030: time=%h pm=%b expected 123000/0", bus.time_bcd, bus.pm);
        end
        press_hr(12); press_min(30);
        vectors++;
        if (bus.time_bcd !== 24'h120000 || bus.pm !== 1'b1) begin
            miscompares++;
            $display("FAIL h12_1200: time=%h pm=%b expected 120000/1", bus.time_bcd, bus.pm);
        end
        press_hr(10);
        vectors++;
        if (bus.time_bcd !== 24'h100000 || bus.pm !== 1'b1) begin
            miscompares++;
            $display("FAIL h12_2200: time=%h pm=%b expected 100000/1", bus.time_bcd, bus.pm);
        end
        press_hr(15); press_min(45);
        vectors++;
        if (bus.time_bcd !== 24'h014500 || bus.pm !== 1'b1) begin
            miscompares++;
            $display("FAIL h12_1345: time=%h pm=%b expected 014500/1", bus.time_bcd, bus.pm);
        end
        bus.mode = 2'b10; bus.alarm_sel = 2'd3; step(1);
        press_hr(13); press_min(46);
        vectors++;
        if (bus.alarm_bcd !== 16'h0146) begin
            miscompares++;
            $display("FAIL h12_alarm: alarm=%h expected 0146", bus.alarm_bcd);
        end
        bus.alarm_en = 4'b1000;
        bus.mode = 2'b00;
        wait_time(24'h014600, 400, "reach_1346_h12");
        vectors++;
        if (bus.ring !== 1'b1 || bus.ring_id !== 2'd3) begin
            miscompares++;
            $display("FAIL h12_ring: ring=%b id=%0d expected 1/3", bus.ring, bus.ring_id);
        end
        bus.hour12 = 1'b0; step(1);
        vectors++;
        if (bus.time_bcd !== 24'h134600 || bus.pm !== 1'b0) begin
            miscompares++;
            $display("FAIL h24_1346: time=%h pm=%b expected 134600/0", bus.time_bcd, bus.pm);
        end
    endtask

    initial begin
        bus.mode      = 2'b00;
        bus.alarm_sel = 2'd0;
        bus.inc_hr    = 1'b0;
        bus.inc_min   = 1'b0;
        bus.alarm_en  = 4'b0000;
        bus.snooze    = 1'b0;
        bus.stop      = 1'b0;
        bus.hour12    = 1'b0;
        test_reset();
        test_tick();
        test_set_time();
        test_alarm_snooze_timeout();
        test_stop_snooze_same();
        test_enable_clear();
        test_reset_while_snoozing();
        test_hour12();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
